// File: rtl/yx_rr_arbiter.sv
// yx_rr_arbiter
//   Switch allocator for a five-port (N, S, W, E, L) 2D-mesh router.
//   Each input header is routed YX-first; each output runs a 4-way
//   round-robin arbiter over the inputs that are not its own port, and
//   stays locked to the winning input until that input's tail is sampled.
//
// Ports (p in {n, s, w, e, l}):
//   clk, rst          rising-edge clock, synchronous active-high reset
//   cur_x, cur_y      this router's mesh coordinates
//   p_req             input p has a header/flit pending
//   p_dst_x, p_dst_y  destination coordinates from p's header
//   p_tail            flit moving on input p this cycle is the tail
//   p_gnt             input p currently owns an output
//   p_out_sel         one-hot owner of output p, bit order {L,E,W,S,N}
//   p_busy            output p is locked to an owner
module yx_rr_arbiter #(
  parameter int X_W = 2,
  parameter int Y_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [X_W-1:0] cur_x,
  input  logic [Y_W-1:0] cur_y,

  input  logic           n_req,
  input  logic [X_W-1:0] n_dst_x,
  input  logic [Y_W-1:0] n_dst_y,
  input  logic           n_tail,
  input  logic           s_req,
  input  logic [X_W-1:0] s_dst_x,
  input  logic [Y_W-1:0] s_dst_y,
  input  logic           s_tail,
  input  logic           w_req,
  input  logic [X_W-1:0] w_dst_x,
  input  logic [Y_W-1:0] w_dst_y,
  input  logic           w_tail,
  input  logic           e_req,
  input  logic [X_W-1:0] e_dst_x,
  input  logic [Y_W-1:0] e_dst_y,
  input  logic           e_tail,
  input  logic           l_req,
  input  logic [X_W-1:0] l_dst_x,
  input  logic [Y_W-1:0] l_dst_y,
  input  logic           l_tail,

  output logic           n_gnt,
  output logic [4:0]     n_out_sel,
  output logic           n_busy,
  output logic           s_gnt,
  output logic [4:0]     s_out_sel,
  output logic           s_busy,
  output logic           w_gnt,
  output logic [4:0]     w_out_sel,
  output logic           w_busy,
  output logic           e_gnt,
  output logic [4:0]     e_out_sel,
  output logic           e_busy,
  output logic           l_gnt,
  output logic [4:0]     l_out_sel,
  output logic           l_busy
);

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_S = 3'd1,
    DIR_W = 3'd2,
    DIR_E = 3'd3,
    DIR_L = 3'd4
  } dir_t;

  // Per-port views indexed by direction code.
  logic [4:0]     req;
  logic [4:0]     tail;
  logic [X_W-1:0] dst_x [5];
  logic [Y_W-1:0] dst_y [5];
  dir_t           route [5];
  logic [4:0]     out_sel [5];
  logic [4:0]     busy;
  logic [4:0]     gnt;

  assign req  = {l_req,  e_req,  w_req,  s_req,  n_req};
  assign tail = {l_tail, e_tail, w_tail, s_tail, n_tail};

  assign dst_x[0] = n_dst_x;
  assign dst_x[1] = s_dst_x;
  assign dst_x[2] = w_dst_x;
  assign dst_x[3] = e_dst_x;
  assign dst_x[4] = l_dst_x;
  assign dst_y[0] = n_dst_y;
  assign dst_y[1] = s_dst_y;
  assign dst_y[2] = w_dst_y;
  assign dst_y[3] = e_dst_y;
  assign dst_y[4] = l_dst_y;

  // YX routing: resolve Y first, then X, else eject locally.
  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      if (dst_y[i] > cur_y)      route[i] = DIR_N;
      else if (dst_y[i] < cur_y) route[i] = DIR_S;
      else if (dst_x[i] > cur_x) route[i] = DIR_E;
      else if (dst_x[i] < cur_x) route[i] = DIR_W;
      else                       route[i] = DIR_L;
    end
  end

  // An input owns at most one output, so OR-ing the owner bits gives its grant.
  always_comb begin
    gnt = '0;
    for (int unsigned o = 0; o < 5; o++) begin
      gnt = gnt | out_sel[o];
    end
  end

  for (genvar o = 0; o < 5; o++) begin : g_out
    localparam logic [2:0] OWN = 3'(o);

    logic [3:0] cand;
    logic [3:0] rr_ptr;
    logic [3:0] rr_ptr_nxt;
    logic [4:0] sel_q;
    logic [4:0] win_in_oh;
    logic       busy_q;
    logic       found;
    logic [1:0] base;
    logic [1:0] pos;
    logic [1:0] win_pos;
    logic [2:0] idx;

    // Candidate j maps to input j below the own port and j+1 above it,
    // which drops the own port and so excludes U-turns by construction.
    always_comb begin
      cand = '0;
      idx  = '0;
      for (int unsigned j = 0; j < 4; j++) begin
        idx     = (3'(j) < OWN) ? 3'(j) : 3'(j) + 3'd1;
        cand[j] = req[idx] && !gnt[idx] && (route[idx] == dir_t'(OWN));
      end
    end

    // Scan from the pointer upward with 2-bit wraparound.
    always_comb begin
      base    = '0;
      pos     = '0;
      win_pos = '0;
      found   = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        if (rr_ptr[k]) base = 2'(k);
      end
      for (int unsigned k = 0; k < 4; k++) begin
        pos = base + 2'(k);
        if (!found && cand[pos]) begin
          found   = 1'b1;
          win_pos = pos;
        end
      end
      win_in_oh = '0;
      if (found) begin
        win_in_oh[({1'b0, win_pos} < OWN) ? {1'b0, win_pos} : {1'b0, win_pos} + 3'd1] = 1'b1;
      end
      rr_ptr_nxt = '0;
      rr_ptr_nxt[win_pos + 2'd1] = 1'b1;
    end

    // The lock is only tested while busy, so a tail on the grant edge
    // or from a non-owner cannot release it.
    always_ff @(posedge clk) begin
      if (rst) begin
        rr_ptr <= 4'b0001;
        sel_q  <= '0;
        busy_q <= 1'b0;
      end else if (busy_q) begin
        if (|(sel_q & tail)) begin
          sel_q  <= '0;
          busy_q <= 1'b0;
        end
      end else if (found) begin
        sel_q  <= win_in_oh;
        busy_q <= 1'b1;
        rr_ptr <= rr_ptr_nxt;
      end
    end

    assign out_sel[o] = sel_q;
    assign busy[o]    = busy_q;
  end

  assign n_out_sel = out_sel[0];
  assign s_out_sel = out_sel[1];
  assign w_out_sel = out_sel[2];
  assign e_out_sel = out_sel[3];
  assign l_out_sel = out_sel[4];

  assign n_busy = busy[0];
  assign s_busy = busy[1];
  assign w_busy = busy[2];
  assign e_busy = busy[3];
  assign l_busy = busy[4];

  assign n_gnt = gnt[0];
  assign s_gnt = gnt[1];
  assign w_gnt = gnt[2];
  assign e_gnt = gnt[3];
  assign l_gnt = gnt[4];

endmodule

// File: tb/tb_yx_rr_arbiter.sv
// Directed bench for yx_rr_arbiter. Index order everywhere: N=0,S=1,W=2,E=3,L=4.
module tb_yx_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] cur_x;
  logic [1:0] cur_y;
  logic [4:0] req_v;
  logic [4:0] tail_v;
  logic [1:0] dx [5];
  logic [1:0] dy [5];

  logic [4:0] sel_v [5];
  logic [4:0] gnt_v;
  logic [4:0] busy_v;

  logic       n_gnt, s_gnt, w_gnt, e_gnt, l_gnt;
  logic       n_busy, s_busy, w_busy, e_busy, l_busy;
  logic [4:0] n_out_sel, s_out_sel, w_out_sel, e_out_sel, l_out_sel;

  int n_checks = 0;
  int n_errors = 0;

  yx_rr_arbiter #(.X_W(2), .Y_W(2)) dut (
    .clk(clk), .rst(rst), .cur_x(cur_x), .cur_y(cur_y),
    .n_req(req_v[0]), .n_dst_x(dx[0]), .n_dst_y(dy[0]), .n_tail(tail_v[0]),
    .s_req(req_v[1]), .s_dst_x(dx[1]), .s_dst_y(dy[1]), .s_tail(tail_v[1]),
    .w_req(req_v[2]), .w_dst_x(dx[2]), .w_dst_y(dy[2]), .w_tail(tail_v[2]),
    .e_req(req_v[3]), .e_dst_x(dx[3]), .e_dst_y(dy[3]), .e_tail(tail_v[3]),
    .l_req(req_v[4]), .l_dst_x(dx[4]), .l_dst_y(dy[4]), .l_tail(tail_v[4]),
    .n_gnt(n_gnt), .n_out_sel(n_out_sel), .n_busy(n_busy),
    .s_gnt(s_gnt), .s_out_sel(s_out_sel), .s_busy(s_busy),
    .w_gnt(w_gnt), .w_out_sel(w_out_sel), .w_busy(w_busy),
    .e_gnt(e_gnt), .e_out_sel(e_out_sel), .e_busy(e_busy),
    .l_gnt(l_gnt), .l_out_sel(l_out_sel), .l_busy(l_busy)
  );

  assign sel_v[0] = n_out_sel;
  assign sel_v[1] = s_out_sel;
  assign sel_v[2] = w_out_sel;
  assign sel_v[3] = e_out_sel;
  assign sel_v[4] = l_out_sel;
  assign gnt_v    = {l_gnt, e_gnt, w_gnt, s_gnt, n_gnt};
  assign busy_v   = {l_busy, e_busy, w_busy, s_busy, n_busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_v  = '0;
    tail_v = '0;
    for (int i = 0; i < 5; i++) begin
      dx[i] = '0;
      dy[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_gnt"},  32'(gnt_v),  32'h0);
    check_eq({tag, "_busy"}, 32'(busy_v), 32'h0);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("%s_sel%0d", tag, i), 32'(sel_v[i]), 32'h0);
    end
  endtask

  logic [4:0] order [4];

  initial begin
    rst   = 1'b1;
    cur_x = 2'd1;
    cur_y = 2'd1;
    clear_inputs();
    do_reset();
    check_idle("reset");

    // Single L packet heading north.
    req_v[4] = 1'b1; dx[4] = 2'd1; dy[4] = 2'd3;
    tick();
    check_eq("l2n_sel",  32'(n_out_sel), 32'b10000);
    check_eq("l2n_gnt",  32'(l_gnt),     32'd1);
    check_eq("l2n_busy", 32'(n_busy),    32'd1);
    req_v[4] = 1'b0; tail_v[4] = 1'b1;
    tick();
    tail_v[4] = 1'b0;
    check_eq("l2n_rel_sel",  32'(n_out_sel), 32'h0);
    check_eq("l2n_rel_busy", 32'(n_busy),    32'h0);

    // Four contenders for N: S, W, E, L in turn with an idle cycle between.
    do_reset();
    for (int i = 1; i < 5; i++) begin
      req_v[i] = 1'b1; dx[i] = 2'd1; dy[i] = 2'd2;
    end
    order[0] = 5'b00010; order[1] = 5'b00100; order[2] = 5'b01000; order[3] = 5'b10000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("rr_own%0d", k), 32'(n_out_sel), 32'(order[k]));
      req_v[k+1]  = 1'b0;
      tail_v[k+1] = 1'b1;
      tick();
      tail_v[k+1] = 1'b0;
      check_eq($sformatf("rr_idle%0d", k), 32'(n_out_sel), 32'h0);
    end
    req_v[1] = 1'b1;
    req_v[2] = 1'b1;
    tick();
    check_eq("rr_wrap", 32'(n_out_sel), 32'b00010);

    // Router (2,2): three inputs to three distinct outputs on one edge.
    do_reset();
    cur_x = 2'd2; cur_y = 2'd2;
    req_v[0] = 1'b1; dx[0] = 2'd0; dy[0] = 2'd2;
    req_v[2] = 1'b1; dx[2] = 2'd2; dy[2] = 2'd2;
    req_v[3] = 1'b1; dx[3] = 2'd2; dy[3] = 2'd0;
    tick();
    check_eq("par_w_sel", 32'(w_out_sel), 32'b00001);
    check_eq("par_l_sel", 32'(l_out_sel), 32'b00100);
    check_eq("par_s_sel", 32'(s_out_sel), 32'b01000);
    check_eq("par_gnt",   32'(gnt_v),     32'b01101);
    check_eq("par_busy",  32'(busy_v),    32'b10110);

    // U-turn L->L never granted.
    do_reset();
    cur_x = 2'd1; cur_y = 2'd1;
    req_v[4] = 1'b1; dx[4] = 2'd1; dy[4] = 2'd1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq($sformatf("uturn_busy%0d", k), 32'(busy_v), 32'h0);
      check_eq($sformatf("uturn_gnt%0d", k),  32'(gnt_v),  32'h0);
    end

    // Reset mid-packet: W locked to N, then reset clears everything.
    do_reset();
    req_v[0] = 1'b1; dx[0] = 2'd0; dy[0] = 2'd1;
    tick();
    check_eq("mid_w_sel", 32'(w_out_sel), 32'b00001);
    req_v[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_rst");
    req_v[1] = 1'b1; dx[1] = 2'd0; dy[1] = 2'd1;
    tick();
    check_eq("mid_s_wins", 32'(w_out_sel), 32'b00010);
    // Pointer back at N position: N beats S when both contend.
    do_reset();
    req_v[0] = 1'b1; dx[0] = 2'd0; dy[0] = 2'd1;
    req_v[1] = 1'b1; dx[1] = 2'd0; dy[1] = 2'd1;
    tick();
    check_eq("ptr_rst_n_wins", 32'(w_out_sel), 32'b00001);

    // E locked to L; tail on the grant edge and a stray N tail are ignored.
    do_reset();
    req_v[4] = 1'b1; dx[4] = 2'd2; dy[4] = 2'd1; tail_v[4] = 1'b1;
    tick();
    tail_v[4] = 1'b0;
    check_eq("e_lock_sel", 32'(e_out_sel), 32'b10000);
    tick();
    check_eq("e_tail_on_gnt_busy", 32'(e_busy), 32'd1);
    tail_v[0] = 1'b1;
    tick();
    tail_v[0] = 1'b0;
    check_eq("stray_busy", 32'(e_busy),    32'd1);
    check_eq("stray_sel",  32'(e_out_sel), 32'b10000);
    req_v[4] = 1'b0; tail_v[4] = 1'b1;
    tick();
    tail_v[4] = 1'b0;
    check_eq("e_rel_busy", 32'(e_busy), 32'd0);
    check_eq("e_rel_gnt",  32'(l_gnt),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
